// File: rtl/tx_config_sequencer.sv
// Sequences atomic configuration commits into the ARTM transmitter: reset hold, PLL lock debounce, retry/fault.
// Optional I/Q mute outside RUN is enabled with the TX_SEQ_MUTE_EN macro.
module tx_config_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 64,
  parameter int TIMEOUT_W     = 20,
  parameter int MAX_RETRY     = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  cfg_mode,
  input  logic [31:0] cfg_bit_rate,
  input  logic [7:0]  cfg_phase_offset,
  input  logic [5:0]  cfg_ctrl,
  input  logic        cfg_commit,
  input  logic        steady_state,
  output logic [3:0]  act_mode,
  output logic [31:0] act_bit_rate,
  output logic [7:0]  act_phase_offset,
  output logic [5:0]  act_ctrl,
  output logic        tx_rst_n,
  output logic        mute,
  output logic        busy,
  output logic        locked,
  output logic        fault,
  output logic [1:0]  retry_cnt
);

  localparam int HOLD_W = $clog2(RST_CYCLES + 1);
  localparam int STAB_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [HOLD_W-1:0]    HOLD_LAST = HOLD_W'(RST_CYCLES - 1);
  localparam logic [STAB_W-1:0]    STAB_LAST = STAB_W'(STABLE_CYCLES - 1);
  localparam logic [TIMEOUT_W-1:0] TO_LAST   = TIMEOUT_W'((64'd1 << TIMEOUT_W) - 64'd2);
  localparam logic [1:0]           RETRY_MAX = 2'(MAX_RETRY);

  typedef enum logic [1:0] {
    ST_HOLD      = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2,
    ST_FAULT     = 2'd3
  } state_t;

  state_t                state_r, state_s;
  logic [HOLD_W-1:0]     hold_cnt_r, hold_cnt_s;
  logic [TIMEOUT_W-1:0]  to_cnt_r, to_cnt_s;
  logic [STAB_W-1:0]     stab_cnt_r, stab_cnt_s;
  logic [1:0]            retry_r, retry_s;
  logic                  fail_s;
  logic [3:0]            act_mode_r;
  logic [31:0]           act_bit_rate_r;
  logic [7:0]            act_phase_offset_r;
  logic [5:0]            act_ctrl_r;
  logic                  tx_rst_n_r, busy_r, locked_r, fault_r;

  // Next-state, counter and retry computation; a commit overrides everything else.
  always_comb begin
    state_s    = state_r;
    hold_cnt_s = hold_cnt_r;
    to_cnt_s   = to_cnt_r;
    stab_cnt_s = stab_cnt_r;
    retry_s    = retry_r;
    fail_s     = 1'b0;
    if (cfg_commit) begin
      state_s    = ST_HOLD;
      hold_cnt_s = {HOLD_W{1'b0}};
      retry_s    = 2'd0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_s    = ST_WAIT_LOCK;
            to_cnt_s   = {TIMEOUT_W{1'b0}};
            stab_cnt_s = {STAB_W{1'b0}};
          end else begin
            hold_cnt_s = hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        ST_WAIT_LOCK: begin
          if (steady_state && (stab_cnt_r == STAB_LAST)) begin
            state_s    = ST_RUN;
            stab_cnt_s = {STAB_W{1'b0}};
          end else if (to_cnt_r == TO_LAST) begin
            fail_s = 1'b1;
          end else begin
            to_cnt_s   = to_cnt_r + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
            stab_cnt_s = steady_state ? (stab_cnt_r + {{(STAB_W-1){1'b0}}, 1'b1}) : {STAB_W{1'b0}};
          end
        end
        ST_RUN: begin
          // Lock loss is debounced symmetrically to lock acquisition.
          if (steady_state) begin
            stab_cnt_s = {STAB_W{1'b0}};
          end else if (stab_cnt_r == STAB_LAST) begin
            fail_s = 1'b1;
          end else begin
            stab_cnt_s = stab_cnt_r + {{(STAB_W-1){1'b0}}, 1'b1};
          end
        end
        ST_FAULT: begin
          state_s = ST_FAULT;
        end
        default: begin
          state_s    = ST_HOLD;
          hold_cnt_s = {HOLD_W{1'b0}};
        end
      endcase
      if (fail_s) begin
        retry_s    = (retry_r == RETRY_MAX) ? retry_r : (retry_r + 2'd1);
        hold_cnt_s = {HOLD_W{1'b0}};
        state_s    = (retry_s == RETRY_MAX) ? ST_FAULT : ST_HOLD;
      end else begin
        retry_s = retry_r;
      end
    end
  end

  // State, counters and all outputs registered; outputs decode the next state so they align with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r            <= ST_HOLD;
      hold_cnt_r         <= {HOLD_W{1'b0}};
      to_cnt_r           <= {TIMEOUT_W{1'b0}};
      stab_cnt_r         <= {STAB_W{1'b0}};
      retry_r            <= 2'd0;
      act_mode_r         <= 4'b0100;
      act_bit_rate_r     <= 32'd0;
      act_phase_offset_r <= 8'd0;
      act_ctrl_r         <= 6'd0;
      tx_rst_n_r         <= 1'b0;
      busy_r             <= 1'b1;
      locked_r           <= 1'b0;
      fault_r            <= 1'b0;
    end else begin
      state_r    <= state_s;
      hold_cnt_r <= hold_cnt_s;
      to_cnt_r   <= to_cnt_s;
      stab_cnt_r <= stab_cnt_s;
      retry_r    <= retry_s;
      if (cfg_commit) begin
        act_mode_r         <= cfg_mode;
        act_bit_rate_r     <= cfg_bit_rate;
        act_phase_offset_r <= cfg_phase_offset;
        act_ctrl_r         <= cfg_ctrl;
      end
      tx_rst_n_r <= (state_s != ST_HOLD);
      busy_r     <= (state_s == ST_HOLD) || (state_s == ST_WAIT_LOCK);
      locked_r   <= (state_s == ST_RUN);
      fault_r    <= (state_s == ST_FAULT);
    end
  end

`ifdef TX_SEQ_MUTE_EN
  logic mute_r;

  // Mute released on the same edge that locked rises.
  always_ff @(posedge clk) begin
    if (rst) begin
      mute_r <= 1'b1;
    end else begin
      mute_r <= (state_s != ST_RUN);
    end
  end

  assign mute = mute_r;
`else
  assign mute = 1'b0;
`endif

  assign act_mode         = act_mode_r;
  assign act_bit_rate     = act_bit_rate_r;
  assign act_phase_offset = act_phase_offset_r;
  assign act_ctrl         = act_ctrl_r;
  assign tx_rst_n         = tx_rst_n_r;
  assign busy             = busy_r;
  assign locked           = locked_r;
  assign fault            = fault_r;
  assign retry_cnt        = retry_r;

endmodule

// File: tb/tb_tx_config_sequencer.sv
// Directed bench for tx_config_sequencer: expected values are queued with each stimulus step and popped at the check.
module tb_tx_config_sequencer;
  localparam int RST_CYCLES = 16;
  localparam int STABLE_CYCLES = 64;
  localparam int TIMEOUT_W = 8;
  localparam int TIMEOUT_CYCLES = (1 << TIMEOUT_W) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  cfg_mode;
  logic [31:0] cfg_bit_rate;
  logic [7:0]  cfg_phase_offset;
  logic [5:0]  cfg_ctrl;
  logic        cfg_commit;
  logic        steady_state;
  logic [3:0]  act_mode;
  logic [31:0] act_bit_rate;
  logic [7:0]  act_phase_offset;
  logic [5:0]  act_ctrl;
  logic        tx_rst_n, mute, busy, locked, fault;
  logic [1:0]  retry_cnt;

  int total = 0;
  int bad = 0;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;
  exp_t exp_q[$];

  tx_config_sequencer #(
    .RST_CYCLES(RST_CYCLES), .STABLE_CYCLES(STABLE_CYCLES),
    .TIMEOUT_W(TIMEOUT_W), .MAX_RETRY(3)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_mode(cfg_mode), .cfg_bit_rate(cfg_bit_rate),
    .cfg_phase_offset(cfg_phase_offset), .cfg_ctrl(cfg_ctrl),
    .cfg_commit(cfg_commit), .steady_state(steady_state),
    .act_mode(act_mode), .act_bit_rate(act_bit_rate),
    .act_phase_offset(act_phase_offset), .act_ctrl(act_ctrl),
    .tx_rst_n(tx_rst_n), .mute(mute), .busy(busy), .locked(locked),
    .fault(fault), .retry_cnt(retry_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic exp_mute(input logic in_run);
`ifdef TX_SEQ_MUTE_EN
    return ~in_run;
`else
    return 1'b0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL queue_empty observed=%0h expected=none", obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e.val) else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic cond_met(input int which);
    case (which)
      0: return tx_rst_n === 1'b1;
      1: return tx_rst_n === 1'b0;
      2: return locked === 1'b1;
      3: return fault === 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Counts cycles until the condition holds; the bound makes a hang show up as a wrong count.
  task automatic wait_cond(input int which, input int lim, output int n);
    n = 0;
    while (!cond_met(which) && n < lim) begin
      tick();
      n++;
    end
  endtask

  task automatic commit(input logic [3:0] m, input logic [31:0] r, input logic [7:0] p, input logic [5:0] c);
    cfg_mode = m;
    cfg_bit_rate = r;
    cfg_phase_offset = p;
    cfg_ctrl = c;
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1;
    cfg_mode = 4'd0;
    cfg_bit_rate = 32'd0;
    cfg_phase_offset = 8'd0;
    cfg_ctrl = 6'd0;
    cfg_commit = 1'b0;
    steady_state = 1'b1;
    repeat (3) tick();

    // Reset state
    push("rst_tx_rst_n", 32'd0);  chk({31'd0, tx_rst_n});
    push("rst_busy", 32'd1);      chk({31'd0, busy});
    push("rst_locked", 32'd0);    chk({31'd0, locked});
    push("rst_fault", 32'd0);     chk({31'd0, fault});
    push("rst_retry", 32'd0);     chk({30'd0, retry_cnt});
    push("rst_act_mode", 32'h4);  chk({28'd0, act_mode});
    push("rst_act_rate", 32'd0);  chk(act_bit_rate);
    push("rst_mute", {31'd0, exp_mute(1'b0)}); chk({31'd0, mute});

    // Automatic sequencing of the default set after reset
    rst = 1'b0;
    push("boot_hold_len", RST_CYCLES);
    wait_cond(0, RST_CYCLES + 20, n); chk(n);
    push("boot_lock_len", STABLE_CYCLES);
    wait_cond(2, STABLE_CYCLES + 20, n); chk(n);
    push("boot_act_mode", 32'h4); chk({28'd0, act_mode});
    push("boot_retry", 32'd0);    chk({30'd0, retry_cnt});
    push("boot_mute", {31'd0, exp_mute(1'b1)}); chk({31'd0, mute});

    // Commit while running
    commit(4'b0001, 32'h0001_0000, 8'h5A, 6'b101101);
    push("c1_act_mode", 32'h1);        chk({28'd0, act_mode});
    push("c1_act_rate", 32'h0001_0000); chk(act_bit_rate);
    push("c1_act_phase", 32'h5A);      chk({24'd0, act_phase_offset});
    push("c1_act_ctrl", 32'h2D);       chk({26'd0, act_ctrl});
    push("c1_locked", 32'd0);          chk({31'd0, locked});
    push("c1_tx_rst_n", 32'd0);        chk({31'd0, tx_rst_n});
    push("c1_busy", 32'd1);            chk({31'd0, busy});
    push("c1_mute", {31'd0, exp_mute(1'b0)}); chk({31'd0, mute});
    push("c1_hold_len", RST_CYCLES);
    wait_cond(0, RST_CYCLES + 20, n); chk(n);
    push("c1_lock_len", STABLE_CYCLES);
    wait_cond(2, STABLE_CYCLES + 20, n); chk(n);

    // Lock-loss debounce boundary: 63 low samples tolerated, 64 is a loss
    steady_state = 1'b0;
    repeat (STABLE_CYCLES - 1) tick();
    steady_state = 1'b1;
    repeat (3) tick();
    push("drop63_locked", 32'd1);   chk({31'd0, locked});
    push("drop63_retry", 32'd0);    chk({30'd0, retry_cnt});
    steady_state = 1'b0;
    push("drop64_len", STABLE_CYCLES);
    wait_cond(1, STABLE_CYCLES + 20, n); chk(n);
    push("drop64_retry", 32'd1);    chk({30'd0, retry_cnt});
    push("drop64_locked", 32'd0);   chk({31'd0, locked});
    steady_state = 1'b1;
    push("relock_len", RST_CYCLES + STABLE_CYCLES);
    wait_cond(2, RST_CYCLES + STABLE_CYCLES + 20, n); chk(n);
    push("relock_retry_kept", 32'd1); chk({30'd0, retry_cnt});

    // Lock never comes: three timeouts then FAULT
    steady_state = 1'b0;
    commit(4'b0000, 32'h0000_1234, 8'h01, 6'b000011);
    push("to_commit_retry", 32'd0); chk({30'd0, retry_cnt});
    for (int a = 1; a <= 3; a++) begin
      push("to_hold_len", RST_CYCLES);
      wait_cond(0, RST_CYCLES + 20, n); chk(n);
      push("to_wait_len", TIMEOUT_CYCLES);
      if (a < 3) begin
        wait_cond(1, TIMEOUT_CYCLES + 20, n); chk(n);
      end else begin
        wait_cond(3, TIMEOUT_CYCLES + 20, n); chk(n);
      end
      push("to_retry", a);          chk({30'd0, retry_cnt});
    end
    repeat (10) tick();
    push("fault_flag", 32'd1);      chk({31'd0, fault});
    push("fault_tx_rst_n", 32'd1);  chk({31'd0, tx_rst_n});
    push("fault_busy", 32'd0);      chk({31'd0, busy});
    push("fault_act_rate", 32'h1234); chk(act_bit_rate);
    push("fault_mute", {31'd0, exp_mute(1'b0)}); chk({31'd0, mute});
    commit(4'b0100, 32'd7, 8'd0, 6'd0);
    push("clr_fault", 32'd0);       chk({31'd0, fault});
    push("clr_retry", 32'd0);       chk({30'd0, retry_cnt});
    push("clr_tx_rst_n", 32'd0);    chk({31'd0, tx_rst_n});

    // Commit on a timeout edge, then a second commit 5 cycles into the hold
    push("tc_hold1", RST_CYCLES);
    wait_cond(0, RST_CYCLES + 20, n); chk(n);
    push("tc_wait1", TIMEOUT_CYCLES);
    wait_cond(1, TIMEOUT_CYCLES + 20, n); chk(n);
    push("tc_retry1", 32'd1);       chk({30'd0, retry_cnt});
    push("tc_hold2", RST_CYCLES);
    wait_cond(0, RST_CYCLES + 20, n); chk(n);
    repeat (TIMEOUT_CYCLES - 1) tick();
    commit(4'b0001, 32'h0000_00AA, 8'h10, 6'd1);
    push("tc_retry_commit", 32'd0); chk({30'd0, retry_cnt});
    push("tc_tx_rst_n", 32'd0);     chk({31'd0, tx_rst_n});
    push("tc_fault", 32'd0);        chk({31'd0, fault});
    repeat (4) tick();
    commit(4'b0001, 32'h0000_00BB, 8'h20, 6'd2);
    push("tc2_act_rate", 32'hBB);   chk(act_bit_rate);
    push("tc2_hold_len", RST_CYCLES);
    wait_cond(0, RST_CYCLES + 20, n); chk(n);
    push("tc2_retry", 32'd0);       chk({30'd0, retry_cnt});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tx_config_sequencer.md
# tx_config_sequencer

Sequences configuration changes into the 240 MHz ARTM transmitter core. Shadow settings written over SPI are applied as one atomic set when a commit pulse arrives. Around each change the block holds the transmitter in reset, waits for the bit-sync PLL to report steady state, and retries or declares a fault if lock does not come. It sits between the SPI register block and the transmitter on the 120 MHz domain, and drives the transmitter's configuration inputs, its active-low reset and an I/Q mute.

## Interface
Parameters:
- RST_CYCLES, 16: transmitter reset hold length in clk cycles (≥2).
- STABLE_CYCLES, 64: consecutive identical steady_state samples needed to declare lock or loss.
- TIMEOUT_W, 20: width of the lock-timeout counter; timeout is 2^TIMEOUT_W−1 cycles.
- MAX_RETRY, 3: failed lock attempts allowed before FAULT (1..3).

Ports:
- clk  in  1  clock (120 MHz domain)
- rst  in  1  reset, synchronous, active-high
- cfg_mode  in  4  shadow mode (0000 FM/PCM, 0001 SOQPSK, 0100 carrier only)
- cfg_bit_rate  in  32  shadow bit-rate word
- cfg_phase_offset  in  8  shadow IQ phase offset
- cfg_ctrl  in  6  shadow {Diff_en, DAT_SRC, CLK_SRC, RAND, DAT_POL, CLK_POL}
- cfg_commit  in  1  one-cycle pulse: apply the shadow set
- steady_state  in  1  PLL lock indication from the transmitter
- act_mode, act_bit_rate, act_phase_offset, act_ctrl  out  4/32/8/6  applied configuration to the transmitter
- tx_rst_n  out  1  active-low reset to the transmitter
- mute  out  1  force I/Q to zero
- busy  out  1  sequencing in progress (HOLD or WAIT_LOCK)
- locked  out  1  in RUN
- fault  out  1  retries exhausted
- retry_cnt  out  2  failed attempts since the last commit

## Operation
- States:
  - HOLD: tx_rst_n=0, counting RST_CYCLES.
  - WAIT_LOCK: tx_rst_n=1, debouncing steady_state, counting the timeout.
  - RUN: locked=1.
  - FAULT: tx_rst_n=1, fault=1.
- Commit handling:
  - cfg_commit in any state snapshots all cfg_* into act_* on the next edge.
  - The same edge clears retry_cnt and fault, and enters HOLD with the hold counter at 0.
  - Commit during HOLD restarts the hold.
- HOLD → WAIT_LOCK after RST_CYCLES cycles. The timeout and stable counters clear on entry.
- WAIT_LOCK:
  - steady_state high for STABLE_CYCLES consecutive cycles → RUN.
  - Any low sample resets the stable counter.
  - Timeout expiry → retry_cnt+1. If the new value equals MAX_RETRY, go to FAULT; otherwise go to HOLD.
- RUN: steady_state low for STABLE_CYCLES consecutive cycles counts as lock loss and is handled exactly like a timeout (retry_cnt+1, then HOLD or FAULT).
- FAULT is left only by cfg_commit or rst. The transmitter keeps running on act_* so the operator can observe it.
- act_* change only on a commit edge and on rst. They are never modified mid-state.
- retry_cnt saturates at MAX_RETRY.
- Commit coinciding with timeout or lock loss: commit wins and retry_cnt becomes 0.
- Commit coinciding with the RUN transition: commit wins and the next state is HOLD.

## Timing
- Reset values:
  - State HOLD at count 0.
  - act_mode=4'b0100 (carrier only); act_bit_rate, act_phase_offset and act_ctrl = 0.
  - tx_rst_n=0, busy=1, locked=0, fault=0, retry_cnt=0.
  - mute=1 when TX_SEQ_MUTE_EN is defined, else 0.
- After reset the block sequences the default set automatically; no commit is needed.
- Commit at edge n:
  - act_*, tx_rst_n=0 and busy=1 are visible after edge n+1.
  - tx_rst_n rises after edge n+1+RST_CYCLES.
- Lock latency: locked rises STABLE_CYCLES edges after the first of an unbroken run of high steady_state samples in WAIT_LOCK.
- All outputs are registered. Nothing combinational passes from input to output.

## Configuration
- TX_SEQ_MUTE_EN:
  - Defined: mute=1 in every state except RUN, and falls on the same edge that locked rises.
  - Undefined: mute is tied to 0 and no mute logic is generated. All other behaviour is identical.

## Test plan
- Reset release with steady_state tied high and RST_CYCLES=16, STABLE_CYCLES=64 → tx_rst_n rises 16 cycles after reset, locked rises 64 cycles later, act_mode=0100, retry_cnt=0.
- In RUN, commit cfg_mode=0001, cfg_bit_rate=32'h0001_0000 → act_* update on the next edge, locked drops and tx_rst_n=0 for 16 cycles, then relock.
- steady_state tied low with TIMEOUT_W=8 and MAX_RETRY=3 → three HOLD/WAIT_LOCK cycles with retry_cnt stepping 1→2→3, then FAULT with fault=1 and tx_rst_n=1; a subsequent commit clears fault and retry_cnt.
- In RUN, drop steady_state for 63 cycles → stays in RUN. Drop it for 64 cycles → HOLD with retry_cnt=1.
- Commit on the same edge as a timeout, and a second commit 5 cycles into HOLD → retry_cnt=0, hold restarts, tx_rst_n low for 16 cycles measured from the second commit.
- Build without TX_SEQ_MUTE_EN → mute constant 0 through the whole sequence, with all other outputs cycle-identical to the build with the macro defined.
